// File: rtl/hack_screen_arbiter_if.sv
// Bus bundle between the Hack CPU data port, the screen RAM, the video scan-out
// block and hack_screen_arbiter. The slave modport is the arbiter's view.
interface hack_screen_arbiter_if #(
  parameter int WIDTH  = 16,
  parameter int AW     = 13,
  parameter int LINE_W = 8
);
  logic [WIDTH-1:0]  cpu_addr;
  logic              cpu_rd;
  logic              cpu_we;
  logic [WIDTH-1:0]  cpu_wdata;
  logic [WIDTH-1:0]  cpu_rdata;
  logic              cpu_hit;

  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [WIDTH-1:0]  ram_wdata;
  logic [WIDTH-1:0]  ram_rdata;

  logic              vid_line_start;
  logic [LINE_W-1:0] vid_line;
  logic              vid_rd;
  logic [WIDTH-1:0]  vid_data;
  logic              vid_empty;
  logic              fetch_busy;
  logic              underrun;

  modport slave (
    input  cpu_addr, cpu_rd, cpu_we, cpu_wdata, ram_rdata,
           vid_line_start, vid_line, vid_rd,
    output cpu_rdata, cpu_hit, ram_addr, ram_we, ram_wdata,
           vid_data, vid_empty, fetch_busy, underrun
  );

  modport master (
    output cpu_addr, cpu_rd, cpu_we, cpu_wdata, ram_rdata,
           vid_line_start, vid_line, vid_rd,
    input  cpu_rdata, cpu_hit, ram_addr, ram_we, ram_wdata,
           vid_data, vid_empty, fetch_busy, underrun
  );
endinterface

// File: rtl/hack_screen_arbiter.sv
// Screen RAM arbiter: the CPU data port always wins; idle cycles prefetch one
// display line into a line FIFO that the VGA scan-out block drains.
module hack_screen_arbiter #(
  parameter int               WIDTH          = 16,
  parameter logic [WIDTH-1:0] SCREEN_BASE    = 16'h4000,
  parameter int               AW             = 13,
  parameter int               WORDS_PER_LINE = 32,
  parameter int               LINE_W         = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  hack_screen_arbiter_if.slave  bus
);

  localparam int PW = $clog2(WORDS_PER_LINE);
  localparam int CW = $clog2(WORDS_PER_LINE + 1);

  typedef enum logic {
    S_IDLE,
    S_FETCH
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [WIDTH:0]    w_diff;
  logic              w_cpu_hit;
  logic              w_cpu_claim;
  logic [AW-1:0]     w_cpu_off;

  logic              w_start;
  logic [LINE_W-1:0] w_line;
  logic [AW-1:0]     w_line_base;
  logic [AW-1:0]     r_fetch_ptr;
  logic [CW-1:0]     r_issued;
  logic              r_pend;
  logic              w_words_left;
  logic              w_issue;

  logic [WIDTH-1:0]  r_mem [WORDS_PER_LINE];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              r_underrun;

  // Decode with a borrow bit so addresses below the window cannot alias into it.
  assign w_diff      = {1'b0, bus.cpu_addr} - {1'b0, SCREEN_BASE};
  assign w_cpu_hit   = !w_diff[WIDTH] && (w_diff[WIDTH-1:AW] == '0);
  assign w_cpu_off   = w_diff[AW-1:0];
  assign w_cpu_claim = w_cpu_hit && (bus.cpu_rd || bus.cpu_we);

  assign w_start      = bus.vid_line_start;
  assign w_line       = bus.vid_line;
  assign w_line_base  = AW'(32'(w_line) * WORDS_PER_LINE);
  assign w_words_left = (r_issued != CW'(WORDS_PER_LINE));
  assign w_issue      = (r_state == S_FETCH) && w_words_left && !w_cpu_claim;

  assign w_empty = (r_count == '0);
  assign w_push  = r_pend && !w_start;
  assign w_pop   = bus.vid_rd && !w_empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (w_start)            w_state_nxt = S_FETCH;
        else if (!w_words_left) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The last read pushes on the same edge that returns the engine to idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_ptr <= '0;
      r_issued    <= '0;
      r_pend      <= 1'b0;
    end else if (w_start) begin
      r_fetch_ptr <= w_line_base;
      r_issued    <= '0;
      r_pend      <= 1'b0;
    end else begin
      r_pend <= w_issue;
      if (w_issue) begin
        r_fetch_ptr <= r_fetch_ptr + AW'(1);
        r_issued    <= r_issued + CW'(1);
      end
    end
  end

  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    if (w_cpu_claim) begin
      bus.ram_addr  = w_cpu_off;
      bus.ram_we    = bus.cpu_we;
      bus.ram_wdata = bus.cpu_wdata;
    end else if (w_issue) begin
      bus.ram_addr = r_fetch_ptr;
    end
  end

  // NOTE: FIFO storage has no reset; the empty flag guards every read of it.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.ram_rdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_start) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PW'(WORDS_PER_LINE - 1)) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(WORDS_PER_LINE - 1)) ? '0 : r_rd_ptr + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_underrun <= 1'b0;
    end else if (bus.vid_rd && w_empty) begin
      r_underrun <= 1'b1;
    end
  end

  assign bus.cpu_rdata  = bus.ram_rdata;
  assign bus.cpu_hit    = w_cpu_hit;
  assign bus.vid_data   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.vid_empty  = w_empty;
  assign bus.fetch_busy = (r_state == S_FETCH);
  assign bus.underrun   = r_underrun;

endmodule
